// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode 7-segment scanner.
// Latches a packed hex word plus decimal points on data_en and drives one
// digit at a time, with live per-digit blanking and blinking, and a pulse
// when the scan wraps back to digit 0.
// Optional feature macro: SEG_LZB_EN compiles in leading-zero blanking.
module seg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_CYCLES  = 200000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  data_en,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     led_en,
    output logic [7:0]            led,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(SCAN_CYCLES);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] EN_RESET = ~(DIGITS'(1));

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [FRM_W-1:0]    frm;
    logic                blink_ph;
    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   dp_q;

    logic                cnt_done;
    logic                wrap;
    logic [DIGITS-1:0]   suppress;
    logic [3:0]          nib;
    logic                dp_bit;
    logic                blank_bit;
    logic                blink_bit;
    logic                sup_bit;
    logic [DIGITS-1:0]   en_next;
    logic [7:0]          seg_next;

    // Segment patterns for a hex nibble, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_pattern(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h18;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h27;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign cnt_done = (cnt == CNT_LAST);
    assign wrap     = cnt_done && (idx == IDX_LAST);

    // Capture the display word and decimal points on the CPU strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            dp_q   <= '0;
        end else if (data_en) begin
            data_q <= data;
            dp_q   <= dp_mask;
        end
    end

    // Dwell counter and digit index; idx is the only scan state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_done) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Count completed frames and flip the blink phase every BLINK_FRAMES of them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm      <= '0;
            blink_ph <= 1'b0;
        end else if (wrap) begin
            if (frm == FRM_LAST) begin
                frm      <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                frm <= frm + 1'b1;
            end
        end
    end

    // Mark the digits hidden by leading-zero blanking (digit 0 always shows)
    always_comb begin
        suppress = '0;
`ifdef SEG_LZB_EN
        begin : lzb_scan
            logic zero_run;
            zero_run = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                zero_run    = zero_run && (data_q[4*i +: 4] == 4'h0);
                suppress[i] = zero_run;
            end
        end
`endif
    end

    // Select the current digit's attributes and resolve its segment pattern
    always_comb begin
        nib       = 4'h0;
        dp_bit    = 1'b0;
        blank_bit = 1'b0;
        blink_bit = 1'b0;
        sup_bit   = 1'b0;
        en_next   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib        = data_q[4*i +: 4];
                dp_bit     = dp_q[i];
                blank_bit  = blank_mask[i];
                blink_bit  = blink_mask[i];
                sup_bit    = suppress[i];
                en_next[i] = 1'b0;
            end
        end
        if (blank_bit || (blink_ph && blink_bit)) begin
            seg_next = 8'hFF;
        end else if (sup_bit) begin
            seg_next = {~dp_bit, 7'h7F};
        end else begin
            seg_next = {~dp_bit, hex_pattern(nib)};
        end
    end

    // Register enable and pattern together so they can never disagree on the pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en     <= EN_RESET;
            led        <= 8'hC0;
            frame_done <= 1'b0;
        end else begin
            led_en     <= en_next;
            led        <= seg_next;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with DIGITS=8,
// SCAN_CYCLES=4, BLINK_FRAMES=2. Expected digit patterns are hand-entered
// tables; digit position, blink phase and frame pulse follow from the
// number of clock edges since reset release.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic        dataEn;
    logic [7:0]  dpMask;
    logic [7:0]  blankMask;
    logic [7:0]  blinkMask;
    logic [7:0]  ledEn;
    logic [7:0]  led;
    logic        frameDone;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [63:0] patQ;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS      (8),
        .SCAN_CYCLES (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .data_en   (dataEn),
        .dp_mask   (dpMask),
        .blank_mask(blankMask),
        .blink_mask(blinkMask),
        .led_en    (ledEn),
        .led       (led),
        .frame_done(frameDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [7:0] dp,
                                 input logic [7:0] blank, input logic [7:0] blink,
                                 input logic en);
        data      = d;
        dpMask    = dp;
        blankMask = blank;
        blinkMask = blink;
        dataEn    = en;
    endtask

    // Advance one edge and compare outputs on the following falling edge
    task automatic stepAndCheck();
        int         d;
        int         ph;
        logic [7:0] expLed;
        logic [7:0] expEn;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        d      = ((cyc - 1) / 4) % 8;
        ph     = ((cyc - 1) / 64) % 2;
        expEn  = ~(8'h01 << d);
        expLed = patQ[d*8 +: 8];
        if (blankMask[d] || (ph == 1 && blinkMask[d])) expLed = 8'hFF;
        checkOutput("led_en", ledEn, expEn);
        checkOutput("led", led, expLed);
        checkOutput("frame_done", frameDone, (cyc % 32 == 0));
    endtask

    task automatic runCycles(input int n);
        repeat (n) stepAndCheck();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(32'h0, 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset_led_en", ledEn, 8'hFE);
        checkOutput("reset_led", led, 8'hC0);
        checkOutput("reset_frame_done", frameDone, 1'b0);

        // Release and load 89ABCDEF on the first edge; digit 0 shows old data once
        rst  = 1'b0;
        cyc  = 0;
        patQ = 64'hC0C0_C0C0_C0C0_C0C0;
        applyStimulus(32'h89AB_CDEF, 8'h00, 8'h00, 8'h00, 1'b1);
        stepAndCheck();
        applyStimulus(32'h89AB_CDEF, 8'h00, 8'h00, 8'h00, 1'b0);
        patQ = 64'h8098_8883_A7A1_868E;
        runCycles(63);

        // Decimal point on digit 0, blank digit 1
        applyStimulus(32'h89AB_CDEF, 8'h01, 8'h02, 8'h00, 1'b1);
        stepAndCheck();
        applyStimulus(32'h89AB_CDEF, 8'h01, 8'h02, 8'h00, 1'b0);
        patQ = 64'h8098_8883_A7A1_860E;
        runCycles(31);

        // Blink digit 7 across two full phase periods
        applyStimulus(32'h89AB_CDEF, 8'h01, 8'h02, 8'h80, 1'b0);
        runCycles(163);

        // Load new data on the edge where idx advances from 0 to 1
        applyStimulus(32'h0000_0100, 8'h00, 8'h00, 8'h00, 1'b1);
        stepAndCheck();
        applyStimulus(32'h0000_0100, 8'h00, 8'h00, 8'h00, 1'b0);
`ifdef SEG_LZB_EN
        patQ = 64'hFFFF_FFFF_FFF9_C0C0;
`else
        patQ = 64'hC0C0_C0C0_C0F9_C0C0;
`endif
        runCycles(48);

        // Reset while idx=5 (digit 4 currently on the pins)
        rst = 1'b1;
        #1;
        checkOutput("midrst_led_en", ledEn, 8'hFE);
        checkOutput("midrst_led", led, 8'hC0);
        checkOutput("midrst_frame_done", frameDone, 1'b0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        cyc  = 0;
        patQ = 64'hC0C0_C0C0_C0C0_C0C0;
        runCycles(36);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised time-multiplexed 7-segment display controller for the board's common-anode digit bank: latches a packed hex word on a strobe and scans it one digit at a time. It sits between the CPU's memory-mapped display register and the board pins. It generalises the fixed 8-digit scanner with configurable digit count and scan period, plus per-digit decimal points, blanking, blinking, a frame-done pulse and optional leading-zero suppression.

## Interface
- DIGITS, 8: number of digits scanned; range 1..16.
- SCAN_CYCLES, 200000: clk cycles each digit stays enabled; minimum 2. Default is 2 ms at 100 MHz.
- BLINK_FRAMES, 125: complete scan frames per blink half-period; minimum 1.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- data  in  4*DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is the least significant.
- data_en  in  1  latch strobe for data and dp_mask.
- dp_mask  in  DIGITS  bit i set lights the decimal point of digit i.
- blank_mask  in  DIGITS  bit i set forces digit i dark; live input, not latched.
- blink_mask  in  DIGITS  bit i set makes digit i blink; live input, not latched.
- led_en  out  DIGITS  digit enables, active-low, one-hot-low.
- led  out  8  segment bits {dp,g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 back to digit 0.

## Operation
- Latch:
  - data_en=1 at an edge loads data_q<=data and dp_q<=dp_mask.
  - Otherwise both registers hold.
- Scan counter:
  - cnt has width $clog2(SCAN_CYCLES) and counts 0..SCAN_CYCLES-1.
  - At the terminal count it returns to 0 and advances idx.
  - idx wraps from DIGITS-1 to 0.
- Blink:
  - blink_ph toggles after every BLINK_FRAMES wraps of idx.
  - The frame counter resets to 0 at each toggle.
- Digit pipeline (single state register idx; no other FSM):
  - Each cycle, led_en <= ~(1<<idx).
  - Each cycle, led <= seg(idx).
- seg(i) is resolved in priority order:
  1. If blank_mask[i] is set, or blink_ph=1 and blink_mask[i] is set: 8'hFF (dp off too).
  2. If digit i is leading-zero suppressed (see Configuration): 8'hFF with bit7 = ~dp_q[i].
  3. Otherwise: the hex pattern of nibble i with bit7 = ~dp_q[i].
- Hex patterns, dp off, for 0..F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 98, 88, 83, A7, A1, 86, 8E.
- DIGITS=1: idx stays 0; frame_done pulses at every scan-counter terminal count.

## Timing
- Reset values:
  - cnt=0, idx=0, frame counter=0, blink_ph=0.
  - data_q=0, dp_q=0.
  - led_en = all ones except bit0 = 0.
  - led = 8'hC0.
  - frame_done=0.
- Output latency:
  - led_en and led are registered and always change on the same edge, so the enable and the pattern are never mismatched.
  - They lag idx by one cycle.
- Digit dwell:
  - Each digit is enabled for exactly SCAN_CYCLES cycles.
  - One frame is DIGITS*SCAN_CYCLES cycles.
- data_en latency:
  - data_en sampled at edge k updates data_q at k.
  - The current digit's led shows the new value from edge k+1.
- Digit advance and data_en on the same edge: both take effect. The new digit is displayed with the new data from edge k+1.
- frame_done is asserted for the cycle following the edge where idx goes DIGITS-1 -> 0.
- Blink:
  - blink_ph toggles on the same edge that completes the BLINK_FRAMES-th wrap.
  - Its effect reaches led one cycle later.
- blank_mask and blink_mask changes reach led after one cycle; they do not wait for a digit boundary.
- rst mid-scan:
  - All state returns to reset values immediately (asynchronous).
  - The scan restarts at digit 0 on the first edge after release.

## Configuration
- SEG_LZB_EN defined (leading-zero blanking compiled in):
  - Scanning from digit DIGITS-1 downward, every digit whose data_q nibble is 0 is suppressed, up to the first nonzero nibble.
  - Digit 0 is never suppressed.
  - The decimal point of a suppressed digit still follows dp_q.
- SEG_LZB_EN undefined: rule 2 is absent and every digit shows its hex pattern. Example: 32'h0000_00A5 displays as 000000A5.

## Test plan
- Reset and scan, DIGITS=8, SCAN_CYCLES=4:
  - Stimulus: hold rst, release; data_en=1 with data=32'h89AB_CDEF.
  - Required: led_en steps FE, FD, FB, ... 7F, 4 cycles each, one digit per step.
  - Required: led = 8E, 86, A1, A7, 83, 88, 98, 80.
  - Required: frame_done is a single-cycle pulse every 32 cycles.
- Decimal point and blank:
  - Stimulus: dp_mask=8'h01, blank_mask=8'h02.
  - Required: digit 0 shows 0E (F with dp lit); digit 1 shows FF.
- Blink, BLINK_FRAMES=2, blink_mask=8'h80:
  - Required: digit 7 shows its pattern for 2 frames, then FF for 2 frames, repeating.
  - Required: the other digits are unaffected.
- Leading-zero blanking:
  - With SEG_LZB_EN and data=32'h0000_0100: digits 7..3 show FF; digits 2..0 show F9, C0, C0.
  - Without SEG_LZB_EN, same data: digits 7..3 show C0.
- Same-edge events:
  - Stimulus: pulse data_en on the exact edge where idx advances.
  - Required: the new digit shows new data from the next cycle, with no stale-pattern cycle.
- Reset mid-frame:
  - Stimulus: assert rst while idx=5.
  - Required: led_en=FE and led=C0 immediately.
  - Required: after release, data_q=0 and the scan restarts at digit 0.
